// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: sequencer state encoding and
// the default operand width shared with the accumulator.
`timescale 1ns/1ps

package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage : mult_pkg

// File: rtl/shift_add_sequencer.sv
// Control stage of the shift-add multiplier: flushes the accumulator, then walks the
// multiplier LSB-first driving add_shift/A. Optional macro EARLY_TERM_EN ends RUN once
// no set multiplier bits remain.
`timescale 1ns/1ps

module shift_add_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH_P = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH_P-1:0] multiplicand,
    input  logic [WIDTH_P-1:0] multiplier,
    output logic               flush,
    output logic               add_shift,
    output logic [WIDTH_P-1:0] A,
    output logic               busy,
    output logic               done
);

    localparam int                CNT_W    = $clog2(WIDTH_P) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH_P - 1);

    seq_state_e         state_r;
    seq_state_e         state_s;
    logic [WIDTH_P-1:0] mcand_r;
    logic [WIDTH_P-1:0] mcand_s;
    logic [WIDTH_P-1:0] mplier_r;
    logic [WIDTH_P-1:0] mplier_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               run_last_s;
    logic               add_shift_s;

    // Final RUN cycle detection; the early-exit term only exists when enabled.
    always_comb begin
`ifdef EARLY_TERM_EN
        run_last_s = (cnt_r == LAST_CNT) || ((mplier_r >> 1) == {WIDTH_P{1'b0}});
`else
        run_last_s = (cnt_r == LAST_CNT);
`endif
    end

    // Next-state and next-datapath computation.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        cnt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_s  = CLEAR;
                    mcand_s  = multiplicand;
                    mplier_s = multiplier;
                    cnt_s    = {CNT_W{1'b0}};
                end else begin
                    state_s  = IDLE;
                end
            end
            CLEAR: begin
                state_s = RUN;
            end
            RUN: begin
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                cnt_s    = cnt_r + CNT_W'(1);
                if (run_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values track the state register.
    always_comb begin
        add_shift_s = (state_s == RUN) && mplier_s[0];
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            mcand_r     <= {WIDTH_P{1'b0}};
            mplier_r    <= {WIDTH_P{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            start_ready <= 1'b1;
            flush       <= 1'b0;
            add_shift   <= 1'b0;
            A           <= {WIDTH_P{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            mcand_r     <= mcand_s;
            mplier_r    <= mplier_s;
            cnt_r       <= cnt_s;
            start_ready <= (state_s == IDLE);
            flush       <= (state_s == CLEAR);
            add_shift   <= add_shift_s;
            A           <= add_shift_s ? mcand_s : {WIDTH_P{1'b0}};
            busy        <= (state_s != IDLE);
            done        <= (state_s == DONE);
        end
    end

endmodule : shift_add_sequencer
